// File: rtl/nsl_ids_pkg.sv
// Shared types, default parameters and fixed-point helpers for the IDS score sequencer.
// Optional feature macro: IDS_SAT_EN (saturating y_k and score arithmetic, see ids_mac_unit).
package nsl_ids_pkg;

    localparam int DEF_PC_NUM     = 32;
    localparam int DEF_MAJ_PC_NUM = 10;
    localparam int DEF_MIN_PC_NUM = 5;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_FRAC       = 16;
    localparam int DEF_SCORE_W    = 64;

    // 1.0 in the default Q16.16 format
    localparam logic [DEF_DATA_W-1:0] FP_ONE = DEF_DATA_W'(1) << DEF_FRAC;

    typedef enum logic [2:0] {
        LOAD   = 3'd0,
        DOT    = 3'd1,
        SQR    = 3'd2,
        SCL    = 3'd3,
        RESULT = 3'd4
    } state_t;

    // Clamp a signed value to the range of a w-bit signed number.
    function automatic logic signed [127:0] sat_signed(input logic signed [127:0] v, input int w);
        logic signed [127:0] max_v;
        logic signed [127:0] min_v;
        max_v = (128'sd1 <<< (w - 1)) - 128'sd1;
        min_v = -(128'sd1 <<< (w - 1));
        if (v > max_v)
            return max_v;
        else if (v < min_v)
            return min_v;
        else
            return v;
    endfunction

    // Keep the low w bits of a signed value and sign-extend them back (two's complement wrap).
    function automatic logic signed [127:0] trunc_signed(input logic signed [127:0] v, input int w);
        return (v <<< (128 - w)) >>> (128 - w);
    endfunction

    // Clamp an unsigned value to 2^w-1.
    function automatic logic [127:0] sat_unsigned(input logic [127:0] v, input int w);
        logic [127:0] max_v;
        max_v = (128'd1 << w) - 128'd1;
        return (v > max_v) ? max_v : v;
    endfunction

    // Map a running component number to its principal-component index:
    // majors 0..maj-1 first, then the minors at the top of the index range.
    function automatic int comp_to_pc(input int comp, input int maj, input int min_n, input int pc_num);
        return (comp < maj) ? comp : comp + (pc_num - min_n - maj);
    endfunction

endpackage

// File: rtl/ids_score_sequencer_if.sv
// Bus bundle of the IDS score sequencer: sample stream, coefficient/eigenvalue ROM ports,
// thresholds and result handshake. The sequencer uses the slave modport.
interface ids_score_sequencer_if #(
    parameter int PC_NUM  = 32,
    parameter int DATA_W  = 32,
    parameter int SCORE_W = 64
) ();
    localparam int CA_W = $clog2(PC_NUM * PC_NUM);
    localparam int LA_W = $clog2(PC_NUM);

    logic               s_valid;
    logic               s_ready;
    logic [DATA_W-1:0]  s_data;
    logic [CA_W-1:0]    coef_addr;
    logic [DATA_W-1:0]  coef_data;
    logic [LA_W-1:0]    lam_addr;
    logic [DATA_W-1:0]  lam_data;
    logic [SCORE_W-1:0] maj_thresh;
    logic [SCORE_W-1:0] min_thresh;
    logic               r_valid;
    logic               r_ready;
    logic [SCORE_W-1:0] maj_score;
    logic [SCORE_W-1:0] min_score;
    logic               alert;

    // Front-end / ROM / sink side
    modport master (
        output s_valid, s_data, coef_data, lam_data, maj_thresh, min_thresh, r_ready,
        input  s_ready, coef_addr, lam_addr, r_valid, maj_score, min_score, alert
    );

    // Sequencer side
    modport slave (
        input  s_valid, s_data, coef_data, lam_data, maj_thresh, min_thresh, r_ready,
        output s_ready, coef_addr, lam_addr, r_valid, maj_score, min_score, alert
    );
endinterface

// File: rtl/ids_mac_unit.sv
// Shared datapath of the IDS score sequencer: dot-product MAC, y_k squaring and
// inverse-eigenvalue scaling into the major/minor score accumulators.
// IDS_SAT_EN defined: y_k clamps to DATA_W signed range, score adds saturate.
// IDS_SAT_EN undefined: y_k wraps, score adds wrap mod 2^SCORE_W.
module ids_mac_unit
    import nsl_ids_pkg::*;
#(
    parameter int PC_NUM  = DEF_PC_NUM,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int FRAC    = DEF_FRAC,
    parameter int SCORE_W = DEF_SCORE_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     acc_clr,
    input  logic                     mac_en,
    input  logic                     sqr_en,
    input  logic                     scl_en,
    input  logic                     scl_maj,
    input  logic                     score_clr,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] coef,
    input  logic        [DATA_W-1:0] lam,
    output logic       [SCORE_W-1:0] maj_score,
    output logic       [SCORE_W-1:0] min_score
);
    localparam int ACC_W = 2 * DATA_W + $clog2(PC_NUM);
    localparam int P_W   = 2 * DATA_W;

    logic signed [ACC_W-1:0]      acc_reg;
    logic        [P_W-1:0]        p_reg;
    logic        [SCORE_W-1:0]    maj_reg;
    logic        [SCORE_W-1:0]    min_reg;

    logic signed [2*DATA_W-1:0]   prod;
    logic signed [127:0]          acc_sh;
    logic signed [DATA_W-1:0]     y;
    logic signed [2*DATA_W-1:0]   ysq;
    logic        [P_W+DATA_W-1:0] scaled;
    logic        [P_W+DATA_W-1:0] term;
    logic        [SCORE_W-1:0]    base;
    logic        [127:0]          sum_wide;
    logic        [SCORE_W-1:0]    score_next;

    assign prod   = x * coef;
    assign acc_sh = 128'(acc_reg) >>> FRAC;

    // Reduce the accumulated projection to a DATA_W-wide y_k
    always_comb begin
`ifdef IDS_SAT_EN
        y = DATA_W'(sat_signed(acc_sh, DATA_W));
`else
        y = DATA_W'(trunc_signed(acc_sh, DATA_W));
`endif
    end

    assign ysq = y * y;

    // Inverse eigenvalues of a covariance matrix are non-negative, so the scale
    // factor is taken as an unsigned magnitude.
    assign scaled   = {{DATA_W{1'b0}}, p_reg} * {{P_W{1'b0}}, lam};
    assign term     = scaled >> FRAC;
    assign base     = scl_maj ? maj_reg : min_reg;
    assign sum_wide = 128'(base) + 128'(term);

    // Score add: saturating or wrapping
    always_comb begin
`ifdef IDS_SAT_EN
        score_next = SCORE_W'(sat_unsigned(sum_wide, SCORE_W));
`else
        score_next = SCORE_W'(sum_wide);
`endif
    end

    // Accumulate, square and scale; each stage is strobed by the sequencer FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_reg <= '0;
            p_reg   <= '0;
            maj_reg <= '0;
            min_reg <= '0;
        end else begin
            if (acc_clr)
                acc_reg <= '0;
            else if (mac_en)
                acc_reg <= acc_reg + ACC_W'(prod);

            if (sqr_en)
                p_reg <= P_W'($unsigned(ysq) >> FRAC);

            if (score_clr) begin
                maj_reg <= '0;
                min_reg <= '0;
            end else if (scl_en) begin
                if (scl_maj)
                    maj_reg <= score_next;
                else
                    min_reg <= score_next;
            end
        end
    end

    assign maj_score = maj_reg;
    assign min_score = min_reg;

endmodule

// File: rtl/ids_score_sequencer.sv
// IDS score sequencer top: buffers one sample, walks the major then minor principal
// components through a single shared MAC datapath, and presents maj/min scores plus
// the threshold alert on a valid/ready result port.
// Optional feature macro: IDS_SAT_EN (handled inside ids_mac_unit; timing unchanged).
module ids_score_sequencer
    import nsl_ids_pkg::*;
#(
    parameter int PC_NUM     = DEF_PC_NUM,
    parameter int MAJ_PC_NUM = DEF_MAJ_PC_NUM,
    parameter int MIN_PC_NUM = DEF_MIN_PC_NUM,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FRAC       = DEF_FRAC,
    parameter int SCORE_W    = DEF_SCORE_W
) (
    input  logic                 clk,
    input  logic                 reset,
    ids_score_sequencer_if.slave bus
);
    localparam int IDX_W  = $clog2(PC_NUM);
    localparam int CA_W   = $clog2(PC_NUM * PC_NUM);
    localparam int CNT_W  = $clog2(PC_NUM + 1);
    localparam int COMP_N = MAJ_PC_NUM + MIN_PC_NUM;
    localparam int COMP_W = $clog2(COMP_N);

    state_t             state_reg;
    logic [IDX_W-1:0]   beat_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [COMP_W-1:0]  comp_reg;
    logic [IDX_W-1:0]   k_reg;
    logic               s_ready_reg;
    logic               r_valid_reg;
    logic               alert_reg;
    logic [CA_W-1:0]    coef_addr_reg;
    logic [IDX_W-1:0]   lam_addr_reg;

    logic [DATA_W-1:0]  x_buf [PC_NUM];
    logic [DATA_W-1:0]  x_rd_reg;

    logic [IDX_W-1:0]   k_next;
    logic               acc_clr;
    logic               mac_en;
    logic               sqr_en;
    logic               scl_en;
    logic               scl_maj;
    logic               score_clr;
    logic [SCORE_W-1:0] maj_score;
    logic [SCORE_W-1:0] min_score;

    assign k_next = IDX_W'(comp_to_pc(int'(comp_reg) + 1, MAJ_PC_NUM, MIN_PC_NUM, PC_NUM));

    // Datapath strobes. cnt_reg==0 in DOT is the ROM latency slot, so MAC starts at 1.
    // The accumulator is cleared in SCL, after SQR has consumed it.
    assign mac_en    = (state_reg == DOT) && (cnt_reg != '0);
    assign sqr_en    = (state_reg == SQR);
    assign scl_en    = (state_reg == SCL);
    assign acc_clr   = (state_reg == SCL);
    assign scl_maj   = (comp_reg < COMP_W'(MAJ_PC_NUM));
    assign score_clr = (state_reg == RESULT) && r_valid_reg && bus.r_ready;

    // Sample buffer (RAM, no reset) with a registered read that lines x_j up with coef_data
    always_ff @(posedge clk) begin
        if (state_reg == LOAD && s_ready_reg && bus.s_valid)
            x_buf[beat_reg] <= bus.s_data;
        x_rd_reg <= x_buf[cnt_reg[IDX_W-1:0]];
    end

    // Sequencer FSM: load beats, per component DOT/SQR/SCL, then hold the result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= LOAD;
            beat_reg      <= '0;
            cnt_reg       <= '0;
            comp_reg      <= '0;
            k_reg         <= '0;
            s_ready_reg   <= 1'b0;
            r_valid_reg   <= 1'b0;
            alert_reg     <= 1'b0;
            coef_addr_reg <= '0;
            lam_addr_reg  <= '0;
        end else begin
            case (state_reg)
                LOAD: begin
                    s_ready_reg <= 1'b1;
                    if (s_ready_reg && bus.s_valid) begin
                        if (beat_reg == IDX_W'(PC_NUM - 1)) begin
                            beat_reg      <= '0;
                            s_ready_reg   <= 1'b0;
                            comp_reg      <= '0;
                            k_reg         <= '0;
                            cnt_reg       <= '0;
                            coef_addr_reg <= '0;
                            lam_addr_reg  <= '0;
                            state_reg     <= DOT;
                        end else begin
                            beat_reg <= beat_reg + IDX_W'(1);
                        end
                    end
                end
                DOT: begin
                    // Address j=0 was issued on entry; issue j=cnt+1 while any remain
                    if (cnt_reg < CNT_W'(PC_NUM - 1))
                        coef_addr_reg <= CA_W'(int'(k_reg) * PC_NUM + int'(cnt_reg) + 1);
                    if (cnt_reg == CNT_W'(PC_NUM))
                        state_reg <= SQR;
                    else
                        cnt_reg <= cnt_reg + CNT_W'(1);
                end
                SQR: begin
                    state_reg <= SCL;
                end
                SCL: begin
                    if (comp_reg == COMP_W'(COMP_N - 1)) begin
                        state_reg <= RESULT;
                    end else begin
                        comp_reg      <= comp_reg + COMP_W'(1);
                        k_reg         <= k_next;
                        cnt_reg       <= '0;
                        coef_addr_reg <= CA_W'(int'(k_next) * PC_NUM);
                        lam_addr_reg  <= k_next;
                        state_reg     <= DOT;
                    end
                end
                RESULT: begin
                    // First RESULT cycle: scores are final, sample thresholds once
                    if (!r_valid_reg) begin
                        r_valid_reg <= 1'b1;
                        alert_reg   <= (maj_score > bus.maj_thresh) || (min_score > bus.min_thresh);
                    end else if (bus.r_ready) begin
                        r_valid_reg <= 1'b0;
                        alert_reg   <= 1'b0;
                        s_ready_reg <= 1'b1;
                        state_reg   <= LOAD;
                    end
                end
                default: begin
                    state_reg <= LOAD;
                end
            endcase
        end
    end

    ids_mac_unit #(
        .PC_NUM  (PC_NUM),
        .DATA_W  (DATA_W),
        .FRAC    (FRAC),
        .SCORE_W (SCORE_W)
    ) u_mac (
        .clk       (clk),
        .reset     (reset),
        .acc_clr   (acc_clr),
        .mac_en    (mac_en),
        .sqr_en    (sqr_en),
        .scl_en    (scl_en),
        .scl_maj   (scl_maj),
        .score_clr (score_clr),
        .x         (x_rd_reg),
        .coef      (bus.coef_data),
        .lam       (bus.lam_data),
        .maj_score (maj_score),
        .min_score (min_score)
    );

    assign bus.s_ready   = s_ready_reg;
    assign bus.r_valid   = r_valid_reg;
    assign bus.alert     = alert_reg;
    assign bus.coef_addr = coef_addr_reg;
    assign bus.lam_addr  = lam_addr_reg;
    assign bus.maj_score = maj_score;
    assign bus.min_score = min_score;

endmodule

// File: tb/tb_ids_score_sequencer.sv
// Directed testbench for ids_score_sequencer: reset, identity-vector scoring,
// threshold boundaries, stalls, mid-compute reset and y_k overflow (IDS_SAT_EN aware).
module tb_ids_score_sequencer;
    import nsl_ids_pkg::*;

    localparam int LATENCY = (DEF_MAJ_PC_NUM + DEF_MIN_PC_NUM) * (DEF_PC_NUM + 3) + 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ids_score_sequencer_if bus ();

    ids_score_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] coef_rom [1024];
    logic [31:0] lam_rom  [32];
    logic [31:0] x_vec    [32];

    // Synchronous ROMs: data one cycle after address
    always @(posedge clk) begin
        bus.coef_data <= coef_rom[bus.coef_addr];
        bus.lam_data  <= lam_rom[bus.lam_addr];
    end

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_identity();
        for (int i = 0; i < 1024; i++) coef_rom[i] = 32'h0;
        for (int k = 0; k < 32; k++) begin
            coef_rom[k * 32 + k] = 32'h0001_0000;
            lam_rom[k]           = 32'h0001_0000;
            x_vec[k]             = 32'(k) << 16;
        end
    endtask

    task automatic load_ones();
        for (int i = 0; i < 1024; i++) coef_rom[i] = 32'h0001_0000;
        for (int k = 0; k < 32; k++) begin
            lam_rom[k] = 32'h0001_0000;
            x_vec[k]   = 32'h7FFF_0000;
        end
    endtask

    // Stream x_vec; returns just after the posedge that accepts the last beat
    task automatic send_sample(input int max_gap);
        int w;
        for (int j = 0; j < 32; j++) begin
            if (max_gap > 0) begin
                repeat ($urandom_range(0, max_gap)) begin
                    @(negedge clk);
                    bus.s_valid = 1'b0;
                end
            end
            @(negedge clk);
            bus.s_valid = 1'b1;
            bus.s_data  = x_vec[j];
            w = 0;
            while (!bus.s_ready && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (w == 20) check_eq("s_ready_timeout", 64'(bus.s_ready), 64'd1);
            @(posedge clk);
        end
    endtask

    task automatic run_case(input string tag, input int max_gap, input int stall,
                            input logic [63:0] maj_th, input logic [63:0] min_th,
                            input logic [63:0] exp_maj, input logic [63:0] exp_min,
                            input logic exp_alert);
        int lat;
        logic stable_ok;
        logic [63:0] maj_h, min_h;
        logic alert_h;
        bus.maj_thresh = maj_th;
        bus.min_thresh = min_th;
        send_sample(max_gap);
        @(negedge clk);
        bus.s_valid = 1'b0;
        lat = 0;
        while (!bus.r_valid && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        $display("[TB] %s maj=0x%0h min=0x%0h alert=%0b latency=%0d",
                 tag, bus.maj_score, bus.min_score, bus.alert, lat);
        check_eq({tag, "_latency"}, 64'(lat), 64'(LATENCY));
        check_eq({tag, "_maj"}, bus.maj_score, exp_maj);
        check_eq({tag, "_min"}, bus.min_score, exp_min);
        check_eq({tag, "_alert"}, 64'(bus.alert), 64'(exp_alert));
        if (stall > 0) begin
            stable_ok = 1'b1;
            maj_h = bus.maj_score;
            min_h = bus.min_score;
            alert_h = bus.alert;
            repeat (stall) begin
                @(negedge clk);
                if (bus.maj_score !== maj_h || bus.min_score !== min_h || bus.alert !== alert_h ||
                    bus.r_valid !== 1'b1 || bus.s_ready !== 1'b0)
                    stable_ok = 1'b0;
            end
            check_eq({tag, "_stall_stable"}, 64'(stable_ok), 64'd1);
        end
        bus.r_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.r_ready = 1'b0;
        check_eq({tag, "_s_ready_after"}, 64'(bus.s_ready), 64'd1);
        check_eq({tag, "_r_valid_after"}, 64'(bus.r_valid), 64'd0);
        check_eq({tag, "_maj_cleared"}, bus.maj_score, 64'd0);
    endtask

    initial begin
        logic [63:0] ovf_maj, ovf_min, ovf_term;

        bus.s_valid    = 1'b0;
        bus.s_data     = '0;
        bus.r_ready    = 1'b0;
        bus.maj_thresh = '0;
        bus.min_thresh = '0;
        load_identity();

        // Reset held for 5 cycles
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("rst_s_ready", 64'(bus.s_ready), 64'd0);
        check_eq("rst_r_valid", 64'(bus.r_valid), 64'd0);
        check_eq("rst_alert", 64'(bus.alert), 64'd0);
        check_eq("rst_maj", bus.maj_score, 64'd0);
        check_eq("rst_min", bus.min_score, 64'd0);
        check_eq("rst_coef_addr", 64'(bus.coef_addr), 64'd0);
        check_eq("rst_lam_addr", 64'(bus.lam_addr), 64'd0);
        reset = 1'b1;
        #1;
        check_eq("rel_s_ready_before_edge", 64'(bus.s_ready), 64'd0);
        @(negedge clk);
        check_eq("rel_s_ready_first_edge", 64'(bus.s_ready), 64'd1);
        $display("[TB] reset sequence done");

        // Identity vectors: maj = 0^2+..+9^2 = 285, min = 27^2+..+31^2 = 4215
        run_case("ident", 0, 0, 64'd300 << 16, 64'd5000 << 16, 64'd285 << 16, 64'd4215 << 16, 1'b0);
        run_case("maj_th284", 0, 0, 64'd284 << 16, 64'd5000 << 16, 64'd285 << 16, 64'd4215 << 16, 1'b1);
        run_case("min_th_eq", 0, 0, 64'd300 << 16, 64'd4215 << 16, 64'd285 << 16, 64'd4215 << 16, 1'b0);
        run_case("min_th4214", 0, 0, 64'd300 << 16, 64'd4214 << 16, 64'd285 << 16, 64'd4215 << 16, 1'b1);
        run_case("gaps_stall", 3, 100, 64'd300 << 16, 64'd5000 << 16, 64'd285 << 16, 64'd4215 << 16, 1'b0);

        // Reset 200 cycles into compute: 5 majors done -> maj = 0+1+4+9+16 = 30
        bus.maj_thresh = 64'd300 << 16;
        bus.min_thresh = 64'd5000 << 16;
        send_sample(0);
        @(negedge clk);
        bus.s_valid = 1'b0;
        repeat (199) @(negedge clk);
        check_eq("mid_maj_partial", bus.maj_score, 64'd30 << 16);
        reset = 1'b0;
        #1;
        check_eq("mid_rst_r_valid", 64'(bus.r_valid), 64'd0);
        check_eq("mid_rst_maj", bus.maj_score, 64'd0);
        check_eq("mid_rst_min", bus.min_score, 64'd0);
        check_eq("mid_rst_s_ready", 64'(bus.s_ready), 64'd0);
        check_eq("mid_rst_coef_addr", 64'(bus.coef_addr), 64'd0);
        $display("[TB] mid-compute reset applied");
        @(negedge clk);
        reset = 1'b1;
        run_case("after_rst", 0, 0, 64'd300 << 16, 64'd5000 << 16, 64'd285 << 16, 64'd4215 << 16, 1'b0);

        // y_k overflow: sum = 32 * 32767.0 = 1048544.0
        load_ones();
`ifdef IDS_SAT_EN
        // y = 0x7FFFFFFF; p = floor((2^31-1)^2 / 2^16) = 2^46 - 2^16
        ovf_term = (64'd1 << 46) - (64'd1 << 16);
`else
        // y wraps to 1048544 - 16*65536 = -32.0; p = 1024.0 = 2^26
        ovf_term = 64'd1 << 26;
`endif
        ovf_maj = ovf_term * 64'd10;
        ovf_min = ovf_term * 64'd5;
        run_case("overflow", 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, ovf_maj, ovf_min, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
